reaction_timer: RTL and testbench

Scoring stage directly downstream of the hit detector (`mouse_on_ball`). It consumes the hit signal and measures the reaction time in milliseconds from each ball spawn to the hit. It keeps last and best reaction times plus hit and miss counters for the score display. Optionally it times out an unhit ball and requests a respawn, which the top level ORs into the `ball_gen` new-ball request.

---
 rtl/reflex_pkg.sv | 23 ++
 rtl/reaction_timer_ms_tick.sv | 35 +++
 rtl/reaction_timer.sv | 155 +++++++++++++++
 tb/tb_reaction_timer.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/reflex_pkg.sv
// reflex_pkg: shared widths, defaults and types for the reflex-game scoring
// path (reaction_timer and its ms_tick prescaler).
//   MS_W       - width of every millisecond quantity (holds 0..9999)
//   CNT_W      - width of the hit / miss counters (saturate at 1023)
//   MAX_MS_DEF - default saturation value of ms quantities
//   rt_state_t - reaction_timer FSM states
package reflex_pkg;

    localparam int MS_W       = 14;
    localparam int CNT_W      = 10;
    localparam int MAX_MS_DEF = 9999;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } rt_state_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/reaction_timer_ms_tick.sv
// ms_tick: free-running prescaler producing one tick every DIV cycles.
// Ports:
//   clk  - system clock
//   rst  - synchronous active-high reset
//   clr  - synchronous clear of the prescaler (restarts the ms phase)
//   tick - high during the last cycle of each DIV-cycle period
// tick depends only on the register, so the caller may derive clr from tick
// without creating a combinational loop.
module ms_tick #(
    parameter int DIV = 100_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clr || tick) cnt_d = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/reaction_timer.sv
// reaction_timer: measures ms from ball spawn (session start or previous hit)
// to the rising edge of the hit level, tracking last/best times and counters.
// Ports:
//   clk, rst      - clock, synchronous active-high reset
//   start         - pulse: start / restart a session
//   hit           - hit-detector level; rising edge counts
//   ball_respawn  - pulse: timed-out ball, request a new one
//   running       - high in RUN
//   last_ms       - most recent reaction time
//   best_ms       - minimum reaction time since reset
//   hit_count     - hits this session (saturating)
//   miss_count    - timeouts this session (saturating)
//   result_valid  - pulse when last_ms updates
// Optional feature macro: REACTION_TIMEOUT_EN enables the miss timeout.
// Without it ball_respawn and miss_count stay 0.
module reaction_timer
    import reflex_pkg::*;
#(
    parameter int CLK_HZ     = 100_000_000,
    parameter int MAX_MS     = MAX_MS_DEF,
    parameter int TIMEOUT_MS = 2000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             hit,
    output logic             ball_respawn,
    output logic             running,
    output logic [MS_W-1:0]  last_ms,
    output logic [MS_W-1:0]  best_ms,
    output logic [CNT_W-1:0] hit_count,
    output logic [CNT_W-1:0] miss_count,
    output logic             result_valid
);

    localparam int DIV = CLK_HZ / 1000;
    localparam logic [MS_W-1:0] MS_MAX = MS_W'(MAX_MS);

    if (TIMEOUT_MS > MAX_MS) begin : g_timeout_range_err
        $error("TIMEOUT_MS must not exceed MAX_MS");
    end

    rt_state_t        state_q, state_d;
    logic [MS_W-1:0]  ms_q, ms_d;
    logic [MS_W-1:0]  last_q, last_d;
    logic [MS_W-1:0]  best_q, best_d;
    logic [CNT_W-1:0] hits_q, hits_d;
    logic [CNT_W-1:0] miss_q, miss_d;
    logic             rv_q, rv_d;
    logic             resp_q, resp_d;
    logic             hit_q;

    logic tick, clr, hit_rise, to_fire;

    // hit_q tracks hit in every state, so a level already high on entering
    // RUN never produces a rise.
    assign hit_rise = hit & ~hit_q;

    ms_tick #(.DIV(DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr),
        .tick (tick)
    );

`ifdef REACTION_TIMEOUT_EN
    // Fires instead of the tick that would bring ms_cnt to TIMEOUT_MS.
    assign to_fire = tick && ({1'b0, ms_q} + 1'b1 == (MS_W+1)'(TIMEOUT_MS));
`else
    assign to_fire = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        ms_d    = ms_q;
        last_d  = last_q;
        best_d  = best_q;
        hits_d  = hits_q;
        miss_d  = miss_q;
        rv_d    = 1'b0;
        resp_d  = 1'b0;
        clr     = 1'b0;
        unique case (state_q)
            IDLE: begin
                // Prescaler held at zero so RUN starts on a fresh ms phase.
                clr = 1'b1;
                if (start) begin
                    state_d = RUN;
                    ms_d    = '0;
                    last_d  = '0;
                    hits_d  = '0;
                    miss_d  = '0;
                end
            end
            RUN: begin
                // start > hit_rise > timeout > tick
                if (start) begin
                    clr    = 1'b1;
                    ms_d   = '0;
                    last_d = '0;
                    hits_d = '0;
                    miss_d = '0;
                end else if (hit_rise) begin
                    clr    = 1'b1;
                    ms_d   = '0;
                    last_d = ms_q;
                    if (ms_q < best_q) best_d = ms_q;
                    hits_d = sat_inc(hits_q);
                    rv_d   = 1'b1;
                end else if (to_fire) begin
                    clr    = 1'b1;
                    ms_d   = '0;
                    miss_d = sat_inc(miss_q);
                    resp_d = 1'b1;
                end else if (tick && ms_q != MS_MAX) begin
                    ms_d = ms_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ms_q    <= '0;
            last_q  <= '0;
            best_q  <= MS_MAX;
            hits_q  <= '0;
            miss_q  <= '0;
            rv_q    <= 1'b0;
            resp_q  <= 1'b0;
            hit_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ms_q    <= ms_d;
            last_q  <= last_d;
            best_q  <= best_d;
            hits_q  <= hits_d;
            miss_q  <= miss_d;
            rv_q    <= rv_d;
            resp_q  <= resp_d;
            hit_q   <= hit;
        end
    end

    assign running      = (state_q == RUN);
    assign last_ms      = last_q;
    assign best_ms      = best_q;
    assign hit_count    = hits_q;
    assign miss_count   = miss_q;
    assign result_valid = rv_q;
    assign ball_respawn = resp_q;

endmodule

// File: tb/tb_reaction_timer.sv
// Bench for reaction_timer at CLK_HZ=4000 (4 cycles per ms). A reference
// model tracks elapsed cycles since the last spawn and derives ms by division;
// every cycle all outputs are compared against it, plus directed checks.
module tb_reaction_timer;

    localparam int DIV  = 4;
    localparam int MAXV = 9999;
    localparam int TO   = 5;

    logic        clk = 1'b0;
    logic        rst, start, hit;
    logic        ball_respawn, running, result_valid;
    logic [13:0] last_ms, best_ms;
    logic [9:0]  hit_count, miss_count;

    int ntests = 0;
    int nfail  = 0;
    bit chk_en = 1'b0;

    reaction_timer #(.CLK_HZ(4000), .MAX_MS(MAXV), .TIMEOUT_MS(TO)) dut (
        .clk(clk), .rst(rst), .start(start), .hit(hit),
        .ball_respawn(ball_respawn), .running(running),
        .last_ms(last_ms), .best_ms(best_ms),
        .hit_count(hit_count), .miss_count(miss_count),
        .result_valid(result_valid)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    bit m_run = 0, m_rv = 0, m_resp = 0, m_hitq = 0;
    int m_el = 0, m_last = 0, m_best = MAXV, m_hits = 0, m_miss = 0;
    bit n_run, n_rv, n_resp, n_hitq;
    int n_el, n_last, n_best, n_hits, n_miss, cur_ms;

    always_comb begin
        n_run = m_run; n_el = m_el; n_last = m_last; n_best = m_best;
        n_hits = m_hits; n_miss = m_miss; n_rv = 0; n_resp = 0; n_hitq = hit;
        cur_ms = (m_el / DIV > MAXV) ? MAXV : m_el / DIV;
        if (rst) begin
            n_run = 0; n_el = 0; n_last = 0; n_best = MAXV;
            n_hits = 0; n_miss = 0; n_hitq = 0;
        end else if (!m_run) begin
            if (start) begin
                n_run = 1; n_el = 0; n_last = 0; n_hits = 0; n_miss = 0;
            end
        end else if (start) begin
            n_el = 0; n_last = 0; n_hits = 0; n_miss = 0;
        end else if (hit && !m_hitq) begin
            n_last = cur_ms;
            if (cur_ms < m_best) n_best = cur_ms;
            n_hits = (m_hits < 1023) ? m_hits + 1 : 1023;
            n_rv = 1; n_el = 0;
`ifdef REACTION_TIMEOUT_EN
        end else if (m_el + 1 == TO * DIV) begin
            n_el = 0; n_resp = 1;
            n_miss = (m_miss < 1023) ? m_miss + 1 : 1023;
`endif
        end else begin
            n_el = m_el + 1;
        end
    end

    always @(posedge clk) begin
        m_run <= n_run; m_el <= n_el; m_last <= n_last; m_best <= n_best;
        m_hits <= n_hits; m_miss <= n_miss; m_rv <= n_rv; m_resp <= n_resp;
        m_hitq <= n_hitq;
    end

    // ---------------- checking ----------------
    task automatic chk(input string name, input int act, input int exp);
        ntests++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic cmp_model();
        chk("m.running", int'(running), int'(m_run));
        chk("m.last_ms", int'(last_ms), m_last);
        chk("m.best_ms", int'(best_ms), m_best);
        chk("m.hit_count", int'(hit_count), m_hits);
        chk("m.miss_count", int'(miss_count), m_miss);
        chk("m.result_valid", int'(result_valid), int'(m_rv));
        chk("m.ball_respawn", int'(ball_respawn), int'(m_resp));
    endtask

    // Advance one edge, then compare away from it.
    task automatic step();
        @(posedge clk);
        #1;
        if (chk_en) cmp_model();
    endtask

    typedef struct {
        int low;
        int hold;
        int exp_last;
        int exp_best;
        int exp_hits;
    } vec_t;

    vec_t vecs[4];

    initial begin
        // low cycles then a hit held for 'hold' cycles; elapsed at the
        // recorded edge is (prev hold - 1) + low, or low for the first one.
        vecs[0] = '{80, 10, 20, 20, 1};
        vecs[1] = '{39, 10, 12, 12, 2};
        vecs[2] = '{111, 10, 30, 12, 3};
        vecs[3] = '{1, 10, 2, 2, 4};

        rst = 1; start = 0; hit = 0;
        step(); step();
        rst = 0;
        chk_en = 1;
        chk("rst.running", int'(running), 0);
        chk("rst.best_ms", int'(best_ms), MAXV);
        chk("rst.last_ms", int'(last_ms), 0);
        chk("rst.hit_count", int'(hit_count), 0);

`ifndef REACTION_TIMEOUT_EN
        // 40 cycles into the session -> 10 ms
        start = 1; step(); start = 0;
        chk("start.running", int'(running), 1);
        repeat (40) step();
        hit = 1; step();
        chk("s1.last_ms", int'(last_ms), 10);
        chk("s1.best_ms", int'(best_ms), 10);
        chk("s1.hit_count", int'(hit_count), 1);
        chk("s1.result_valid", int'(result_valid), 1);
        step();
        chk("s1.rv_width", int'(result_valid), 0);
        hit = 0;
        rst = 1; step(); rst = 0;

        start = 1; step(); start = 0;
        foreach (vecs[i]) begin
            hit = 0;
            repeat (vecs[i].low) step();
            hit = 1; step();
            chk("tbl.last_ms", int'(last_ms), vecs[i].exp_last);
            chk("tbl.best_ms", int'(best_ms), vecs[i].exp_best);
            chk("tbl.hit_count", int'(hit_count), vecs[i].exp_hits);
            chk("tbl.result_valid", int'(result_valid), 1);
            repeat (vecs[i].hold - 1) step();
            chk("tbl.hold_once", int'(hit_count), vecs[i].exp_hits);
        end

        // saturation: best_ms survives the restart
        hit = 0; start = 1; step(); start = 0;
        repeat (50000) step();
        chk("sat.respawn", int'(ball_respawn), 0);
        hit = 1; step();
        chk("sat.last_ms", int'(last_ms), MAXV);
        chk("sat.best_ms", int'(best_ms), 2);
        chk("sat.hit_count", int'(hit_count), 1);
        hit = 0; step();
`else
        begin
            int nresp = 0;
            start = 1; step(); start = 0;
            for (int c = 0; c < 60; c++) begin
                step();
                if (ball_respawn) nresp++;
            end
            chk("to.respawns", nresp, 3);
            chk("to.miss_count", int'(miss_count), 3);
            repeat (19) step();
            hit = 1; step();
            chk("to.hit_wins_last", int'(last_ms), 4);
            chk("to.hit_wins_hits", int'(hit_count), 1);
            chk("to.hit_wins_resp", int'(ball_respawn), 0);
            chk("to.hit_wins_miss", int'(miss_count), 3);
            hit = 0; step();
        end
`endif

        // hit already high on start
        rst = 1; step(); rst = 0;
        hit = 1; step(); step();
        start = 1; step(); start = 0;
        repeat (5) step();
        chk("pre.hit_count", int'(hit_count), 0);
        chk("pre.running", int'(running), 1);
        hit = 0; repeat (3) step();
        hit = 1; step();
        chk("pre.hit_count2", int'(hit_count), 1);
        chk("pre.last_ms", int'(last_ms), 2);
        hit = 0; step();

        // reset mid-session after 7 hits, with a rise in the reset cycle
        start = 1; step(); start = 0;
        for (int k = 0; k < 7; k++) begin
            hit = 1; step();
            hit = 0; step();
        end
        chk("mid.hit_count", int'(hit_count), 7);
        hit = 1; rst = 1; step();
        chk("mid.running", int'(running), 0);
        chk("mid.last_ms", int'(last_ms), 0);
        chk("mid.best_ms", int'(best_ms), MAXV);
        chk("mid.hit_count", int'(hit_count), 0);
        chk("mid.miss_count", int'(miss_count), 0);
        chk("mid.result_valid", int'(result_valid), 0);
        chk("mid.respawn", int'(ball_respawn), 0);
        rst = 0; hit = 0; step();

        // random traffic against the model
        for (int r = 0; r < 3000; r++) begin
            start = ($urandom_range(63) == 0);
            rst   = ($urandom_range(499) == 0);
            if ($urandom_range(7) == 0) hit = ~hit;
            step();
        end
        start = 0; rst = 0;
        step();

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
